// File: rtl/ethernet_frame_parser.sv
// Receive-side Ethernet frame parser: strips preamble/SFD, captures the
// MAC/EtherType header, checks length and CRC-32, and forwards payload
// bytes with the trailing FCS held back by a 4-byte delay line.
module ethernet_frame_parser #(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  receive_data,
    input  logic        receive_data_valid,
    input  logic        receive_error,
    output logic        valid_packet,
    output logic        invalid_packet,
    output logic [47:0] parsed_mac_destination,
    output logic [47:0] parsed_mac_source,
    output logic [15:0] parsed_ether_type,
    output logic [10:0] frame_byte_count,
    output logic [7:0]  payload_data,
    output logic        payload_data_valid
);

    localparam int          DLY         = 4;     // FCS length in bytes
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] CNT_MAX     = 11'h7FF;

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, DEST, SOURCE, TYPE, PAYLOAD, DROP
    } state_t;

    state_t               state, state_nxt;
    logic [2:0]           fld_cnt;     // preamble bytes seen, or byte index within a header field
    logic [31:0]          crc;
    logic [10:0]          byte_cnt;
    logic                 err_seen;
    logic [47:0]          dest_sh, src_sh;
    logic [15:0]          type_sh;
    logic [DLY-1:0][7:0]  dly;         // dly[DLY-1] is the oldest byte
    logic [DLY-1:0]       vld_pipe;
    logic                 in_frame;
    logic                 frame_end;
    logic                 frame_good;

    // One byte of the reflected CRC-32, LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    assign in_frame   = (state == DEST) || (state == SOURCE) || (state == TYPE) || (state == PAYLOAD);
    // Truncation before PAYLOAD can never be good
    assign frame_good = (state == PAYLOAD) && (crc == CRC_RESIDUE) && !err_seen &&
                        (byte_cnt >= 11'(MIN_FRAME_BYTES)) && (byte_cnt <= 11'(MAX_FRAME_BYTES));

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and frame-end detection
    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                // A frame that starts while disabled is dropped whole
                if (receive_data_valid)
                    state_nxt = (enable && receive_data == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!receive_data_valid)                          state_nxt = DROP;
                else if (receive_data == 8'hD5)                   state_nxt = DEST;
                else if (receive_data == 8'h55 && fld_cnt < 3'd7) state_nxt = PREAMBLE;
                else                                              state_nxt = DROP;
            end
            DEST: begin
                if (!receive_data_valid) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end else if (fld_cnt == 3'd5) state_nxt = SOURCE;
            end
            SOURCE: begin
                if (!receive_data_valid) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end else if (fld_cnt == 3'd5) state_nxt = TYPE;
            end
            TYPE: begin
                if (!receive_data_valid) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end else if (fld_cnt == 3'd1) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (!receive_data_valid) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            DROP: begin
                if (!receive_data_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state byte counter; the first preamble byte is consumed in IDLE
    always_ff @(posedge clock) begin
        if (reset)                  fld_cnt <= 3'd0;
        else if (state_nxt != state) fld_cnt <= (state_nxt == PREAMBLE) ? 3'd1 : 3'd0;
        else if (receive_data_valid) fld_cnt <= fld_cnt + 3'd1;
    end

    // CRC, length, error tracking and header shadow capture
    always_ff @(posedge clock) begin
        if (reset) begin
            crc      <= CRC_INIT;
            byte_cnt <= '0;
            err_seen <= 1'b0;
            dest_sh  <= '0;
            src_sh   <= '0;
            type_sh  <= '0;
        end else begin
            if (state == PREAMBLE && receive_data_valid && receive_data == 8'hD5) begin
                crc      <= CRC_INIT;
                byte_cnt <= '0;
                err_seen <= 1'b0;
            end
            if (in_frame && receive_data_valid) begin
                crc <= crc_byte(crc, receive_data);
                if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 11'd1;
                if (receive_error)       err_seen <= 1'b1;
            end
            if (state == DEST && receive_data_valid)   dest_sh <= {dest_sh[39:0], receive_data};
            if (state == SOURCE && receive_data_valid) src_sh  <= {src_sh[39:0], receive_data};
            if (state == TYPE && receive_data_valid)   type_sh <= {type_sh[7:0], receive_data};
        end
    end

    // Payload delay line and frame result outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            dly                    <= '0;
            vld_pipe               <= '0;
            payload_data           <= '0;
            payload_data_valid     <= 1'b0;
            valid_packet           <= 1'b0;
            invalid_packet         <= 1'b0;
            parsed_mac_destination <= '0;
            parsed_mac_source      <= '0;
            parsed_ether_type      <= '0;
            frame_byte_count       <= '0;
        end else begin
            payload_data_valid <= 1'b0;
            valid_packet       <= 1'b0;
            invalid_packet     <= 1'b0;
            if (state == PAYLOAD && receive_data_valid) begin
                dly      <= {dly[DLY-2:0], receive_data};
                vld_pipe <= {vld_pipe[DLY-2:0], 1'b1};
                // Only emit once DLY newer bytes exist, so the FCS never leaks out
                if (vld_pipe[DLY-1]) begin
                    payload_data       <= dly[DLY-1];
                    payload_data_valid <= 1'b1;
                end
            end
            if (frame_end) begin
                vld_pipe         <= '0;
                frame_byte_count <= byte_cnt;
                if (frame_good) begin
                    valid_packet           <= 1'b1;
                    parsed_mac_destination <= dest_sh;
                    parsed_mac_source      <= src_sh;
                    parsed_ether_type      <= type_sh;
                end else begin
                    invalid_packet <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ethernet_frame_parser.md
# ethernet_frame_parser

Receive-side frame parser for the RGMII port. It consumes the byte stream recovered by the port's DDR input capture: one byte per clock plus valid and error qualifiers. It strips preamble/SFD, extracts destination MAC, source MAC and EtherType, checks length and FCS (CRC-32), and forwards payload bytes with the FCS removed. Its `valid_packet`, `invalid_packet`, `parsed_mac_destination` and `parsed_mac_source` outputs drive the identically named ports of the RGMII port toward the switch fabric.

## Interface
- `MIN_FRAME_BYTES`, 64: minimum legal length, destination MAC through FCS inclusive.
- `MAX_FRAME_BYTES`, 1518: maximum legal length, same span.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  parser accepts new frames only while high.
- `receive_data`  in  8  received byte.
- `receive_data_valid`  in  1  byte qualifier; high for the contiguous duration of a frame.
- `receive_error`  in  1  PHY error flag, meaningful only while `receive_data_valid` is high.
- `valid_packet`  out  1  one-cycle pulse: frame passed all checks.
- `invalid_packet`  out  1  one-cycle pulse: frame failed a check.
- `parsed_mac_destination`  out  48  destination MAC of the last good frame.
- `parsed_mac_source`  out  48  source MAC of the last good frame.
- `parsed_ether_type`  out  16  EtherType/length of the last good frame.
- `frame_byte_count`  out  11  length of the last frame ended, valid or not; saturates at 2047.
- `payload_data`  out  8  payload byte, FCS excluded.
- `payload_data_valid`  out  1  qualifier for `payload_data`.

## Operation
- States are IDLE, PREAMBLE, DEST, SOURCE, TYPE, PAYLOAD and DROP.
- **IDLE**
  - Moves to PREAMBLE when `enable`, `receive_data_valid` and `receive_data == 0x55` are all high.
  - A valid byte that is not 0x55 sends the FSM to DROP.
  - `enable` is sampled only in IDLE. A frame in progress completes normally if `enable` falls.
- **PREAMBLE**
  - 0x55 stays in PREAMBLE; 1 to 7 preamble bytes are accepted in total.
  - 0xD5 (SFD) moves to DEST.
  - Any other byte, an 8th 0x55, or valid falling moves to DROP with no pulse. This is not counted as a frame.
- **DEST / SOURCE / TYPE**
  - DEST and SOURCE take 6 bytes each; TYPE takes 2.
  - The first byte received lands in the MSB, e.g. dest[47:40].
  - Fields are captured into shadow registers.
- **PAYLOAD**
  - Runs until `receive_data_valid` is sampled low.
- **DROP**
  - Waits for `receive_data_valid` low, then returns to IDLE.
- **Byte counter**: counts every valid byte from the first DEST byte, saturating at 2047.
- **CRC-32**
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, one byte per cycle, LSB-first.
  - Covers DEST through FCS inclusive.
  - The frame is good when the final register equals the residue 0xDEBB20E3.
- **Frame end**: the first cycle with `receive_data_valid` low while in DEST..PAYLOAD.
  - The frame is good only if: CRC residue matches, AND MIN ≤ count ≤ MAX, AND `receive_error` was never sampled high with valid during the frame.
  - Truncation before PAYLOAD is always bad.
  - The FSM returns to IDLE at frame end.
- **Result on a good frame**: pulse `valid_packet`; copy the shadows to the `parsed_*` outputs.
- **Result on a bad frame**: pulse `invalid_packet`; `parsed_*` hold their previous values.
- **`frame_byte_count`** updates at every frame end.
- **Payload path**
  - Bytes after TYPE enter a 4-deep byte delay line.
  - A byte is emitted only once 4 newer bytes have arrived, so FCS bytes are never emitted.
  - Delay-line contents are discarded at frame end.

## Timing
- **Reset**
  - All outputs reset to 0; the FSM resets to IDLE.
  - CRC resets to 0xFFFFFFFF; the counter and delay line are cleared.
  - Reset mid-frame abandons the frame with no pulse.
- **Result pulse**: if the last byte is sampled at edge N and valid is sampled low at edge N+1, then `valid_packet`/`invalid_packet` is high from N+1 to N+2 (exactly one cycle). `parsed_*` and `frame_byte_count` change at the same edge.
- **Payload latency**: a byte sampled at edge K appears on `payload_data` after the edge that samples the 4th following byte.
  - `payload_data_valid` never asserts after frame end.
  - The last payload byte appears at edge N, before the result pulse.
- **Back-to-back frames**: one idle cycle between frames is sufficient; the next preamble byte is accepted at edge N+2.
- The two result pulses are never high in the same cycle.

## Test plan
- **Good frame**: 7×0x55, 0xD5, dest 0x001122334455, src 0xAABBCCDDEEFF, type 0x0800, 46 payload bytes 0x00..0x2D, correct FCS (64 bytes) -> `valid_packet` pulses once, 2 cycles after the last byte; `parsed_mac_destination`=0x001122334455, `parsed_mac_source`=0xAABBCCDDEEFF, `parsed_ether_type`=0x0800, `frame_byte_count`=64, exactly 46 payload bytes emitted in order.
- **Corrupted FCS**: same frame with the last FCS byte XOR 0x01 -> `invalid_packet` pulses once; `parsed_*` keep the previous values.
- **Runt and oversize**: a 60-byte frame with correct CRC and a 1519-byte frame with correct CRC -> `invalid_packet` for each; `frame_byte_count` = 60 and 1519 respectively.
- **Preamble and error faults**: a frame whose 3rd preamble byte is 0x54 -> no pulse, no payload. A good frame with `receive_error` high for one mid-payload cycle -> `invalid_packet`.
- **Back-to-back**: two good frames separated by one idle cycle -> two `valid_packet` pulses; `parsed_*` reflect the second frame.
- **Reset and enable**: `reset` asserted during the SOURCE field, then a good frame -> no pulse for the first frame, `valid_packet` for the second. `enable` low at frame start -> frame ignored, no pulse.
